// File: rtl/sync_framer_if.sv
// sync_framer_if -- word-stream bundle between an upstream source and the
// sync_framer block.
//   retrain      : source -> framer, synchronous request to restart training
//   valid_in     : source -> framer, datain carries a word
//   datain[15:0] : source -> framer, upstream data word
//   ready        : framer -> source, word accepted this cycle when valid_in
//   valid        : framer -> lane, dataout carries a data or sync word
//   dataout[15:0]: framer -> lane, word towards the serializer
//   training     : framer -> lane, high while the framer is training
//   sync_collide : framer -> lane, emitted data word equals the sync pattern
interface sync_framer_if;
  logic        retrain;
  logic        valid_in;
  logic [15:0] datain;
  logic        ready;
  logic        valid;
  logic [15:0] dataout;
  logic        training;
  logic        sync_collide;

  // Upstream source / testbench side.
  modport master (
    output retrain, valid_in, datain,
    input  ready, valid, dataout, training, sync_collide
  );

  // Framer side.
  modport slave (
    input  retrain, valid_in, datain,
    output ready, valid, dataout, training, sync_collide
  );
endinterface

// File: rtl/sync_framer.sv
// sync_framer -- inserts lane sync words into a 16-bit data stream.
// After reset or a retrain request it sends a training burst of TRAIN_LEN
// sync words, then forwards accepted data words with one cycle of latency.
// Every SYNC_PERIOD accepted words (0 = never) it stalls upstream and emits
// a burst of SYNC_BURST sync words.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : sync_framer_if.slave (retrain/valid_in/datain in; ready/valid/
//          dataout/training/sync_collide out)
module sync_framer #(
  parameter logic [7:0]  TRAIN_LEN   = 8'd32,
  parameter logic [15:0] SYNC_PERIOD = 16'd1024,
  parameter logic [7:0]  SYNC_BURST  = 8'd4
) (
  input  logic          clk,
  input  logic          rst,
  sync_framer_if.slave  bus
);

  localparam logic [15:0] SYNC_WORD = 16'h817E;

  typedef enum logic [1:0] {
    TRAIN,
    DATA,
    INSERT
  } state_t;

  state_t      state_q;
  logic [7:0]  train_cnt_q;
  logic [7:0]  burst_cnt_q;
  logic [15:0] period_cnt_q;
  logic        valid_q;
  logic [15:0] dataout_q;
  logic        collide_q;
  logic        training_q;

  logic        ready_w;
  logic        xfer_w;

  // ready depends only on the state register and retrain, never on valid_in.
  assign ready_w = (state_q == DATA) && !bus.retrain;
  assign xfer_w  = ready_w && bus.valid_in;

  assign bus.ready        = ready_w;
  assign bus.valid        = valid_q;
  assign bus.dataout      = dataout_q;
  assign bus.sync_collide = collide_q;
  assign bus.training     = training_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= TRAIN;
      train_cnt_q  <= '0;
      burst_cnt_q  <= '0;
      period_cnt_q <= '0;
      valid_q      <= 1'b0;
      dataout_q    <= '0;
      collide_q    <= 1'b0;
      training_q   <= 1'b1;
    end else begin
      // training is registered from the state that produced the word now
      // being loaded, so it stays aligned with dataout.
      training_q <= (state_q == TRAIN);
      collide_q  <= 1'b0;

      if (bus.retrain) begin
        // Retrain wins over any terminal count; the sync word loaded here
        // starts training on this edge.
        state_q      <= TRAIN;
        train_cnt_q  <= '0;
        burst_cnt_q  <= '0;
        period_cnt_q <= '0;
        valid_q      <= 1'b1;
        dataout_q    <= SYNC_WORD;
      end else begin
        case (state_q)
          TRAIN: begin
            valid_q   <= 1'b1;
            dataout_q <= SYNC_WORD;
            if (train_cnt_q == TRAIN_LEN - 8'd1) begin
              train_cnt_q <= '0;
              state_q     <= DATA;
            end else begin
              train_cnt_q <= train_cnt_q + 8'd1;
            end
          end

          DATA: begin
            if (xfer_w) begin
              valid_q   <= 1'b1;
              dataout_q <= bus.datain;
              collide_q <= (bus.datain == SYNC_WORD);
              if (SYNC_PERIOD != '0) begin
                if (period_cnt_q == SYNC_PERIOD - 16'd1) begin
                  period_cnt_q <= '0;
                  burst_cnt_q  <= '0;
                  state_q      <= INSERT;
                end else begin
                  period_cnt_q <= period_cnt_q + 16'd1;
                end
              end
            end else begin
              valid_q   <= 1'b0;
              dataout_q <= '0;
            end
          end

          INSERT: begin
            valid_q   <= 1'b1;
            dataout_q <= SYNC_WORD;
            if (burst_cnt_q == SYNC_BURST - 8'd1) begin
              burst_cnt_q <= '0;
              state_q     <= DATA;
            end else begin
              burst_cnt_q <= burst_cnt_q + 8'd1;
            end
          end

          default: begin
            state_q   <= TRAIN;
            valid_q   <= 1'b0;
            dataout_q <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sync_framer.sv
// tb_sync_framer -- self-checking bench for sync_framer.
// Two instances share the stimulus: u0 with default parameters and u1 with
// periodic insertion disabled. Each is compared every cycle against a
// word-stream model that tracks how many training / burst sync words remain
// and how many transfers have happened since the last burst.
module tb_sync_framer;

  localparam logic [15:0] SYNC = 16'h817E;
  localparam int TL    = 32;
  localparam int BURST = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sync_framer_if b0 ();
  sync_framer_if b1 ();

  sync_framer u0 (
    .clk (clk),
    .rst (rst),
    .bus (b0.slave)
  );

  sync_framer #(
    .SYNC_PERIOD (16'd0)
  ) u1 (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
  );

  logic        o_rdy [2];
  logic        o_vld [2];
  logic [15:0] o_dat [2];
  logic        o_col [2];
  logic        o_trn [2];

  assign o_rdy[0] = b0.ready;        assign o_rdy[1] = b1.ready;
  assign o_vld[0] = b0.valid;        assign o_vld[1] = b1.valid;
  assign o_dat[0] = b0.dataout;      assign o_dat[1] = b1.dataout;
  assign o_col[0] = b0.sync_collide; assign o_col[1] = b1.sync_collide;
  assign o_trn[0] = b0.training;     assign o_trn[1] = b1.training;

  int checks = 0;
  int passes = 0;

  // Model state per instance.
  int          m_train [2];
  int          m_ins   [2];
  int          m_xf    [2];
  int          per     [2] = '{1024, 0};

  task automatic chk(input string tag, input int idx, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s[u%0d] observed=%h expected=%h", tag, idx, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_train[i] = TL;
      m_ins[i]   = 0;
      m_xf[i]    = 0;
    end
  endtask

  task automatic chk_reset_outputs();
    for (int i = 0; i < 2; i++) begin
      chk("rst_valid", i, 32'(o_vld[i]), 32'd0);
      chk("rst_data",  i, 32'(o_dat[i]), 32'd0);
      chk("rst_ready", i, 32'(o_rdy[i]), 32'd0);
      chk("rst_coll",  i, 32'(o_col[i]), 32'd0);
      chk("rst_train", i, 32'(o_trn[i]), 32'd1);
    end
  endtask

  // One clock cycle: drive, check ready, clock, check registered outputs.
  // acc reports whether u0 accepted the word.
  task automatic cycle(input logic rt, input logic v, input logic [15:0] d,
                       output bit acc);
    logic        ev, ec, et;
    logic [15:0] ed;
    b0.retrain = rt; b0.valid_in = v; b0.datain = d;
    b1.retrain = rt; b1.valid_in = v; b1.datain = d;
    #1;
    for (int i = 0; i < 2; i++)
      chk("ready", i, 32'(o_rdy[i]),
          32'(m_train[i] == 0 && m_ins[i] == 0 && !rt));
    acc = (m_train[0] == 0 && m_ins[0] == 0 && !rt && v);
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      ev = 1'b1; ed = SYNC; ec = 1'b0; et = 1'b0;
      if (rt) begin
        et = (m_train[i] > 0);
        m_train[i] = TL; m_ins[i] = 0; m_xf[i] = 0;
      end else if (m_train[i] > 0) begin
        et = 1'b1;
        m_train[i]--;
      end else if (m_ins[i] > 0) begin
        m_ins[i]--;
      end else if (v) begin
        ed = d;
        ec = (d == SYNC);
        m_xf[i]++;
        if (per[i] != 0 && m_xf[i] == per[i]) begin
          m_ins[i] = BURST;
          m_xf[i]  = 0;
        end
      end else begin
        ev = 1'b0; ed = '0;
      end
      chk("valid",    i, 32'(o_vld[i]), 32'(ev));
      chk("dataout",  i, 32'(o_dat[i]), 32'(ed));
      chk("collide",  i, 32'(o_col[i]), 32'(ec));
      chk("training", i, 32'(o_trn[i]), 32'(et));
    end
  endtask

  initial begin
    bit          acc;
    int          w;
    int          n;
    logic [15:0] rd;

    b0.retrain = 1'b0; b0.valid_in = 1'b0; b0.datain = '0;
    b1.retrain = 1'b0; b1.valid_in = 1'b0; b1.datain = '0;
    rst = 1'b1;
    model_reset();
    #3;
    chk_reset_outputs();
    @(posedge clk); #1;
    chk_reset_outputs();
    rst = 1'b0;

    // Idle through training and a few cycles beyond.
    for (int k = 0; k < TL + 4; k++) cycle(1'b0, 1'b0, 16'($urandom), acc);

    // 1024 back-to-back words, the periodic burst, then resume.
    w = 0; n = 0;
    while (w < 1030 && n < 1200) begin
      cycle(1'b0, 1'b1, 16'(w), acc);
      if (acc) w++;
      n++;
    end
    chk("stream_words", 0, 32'(w), 32'd1030);

    // Collision word between two ordinary words, with idle gaps.
    cycle(1'b0, 1'b1, 16'h1234, acc);
    cycle(1'b0, 1'b0, 16'h0000, acc);
    cycle(1'b0, 1'b1, SYNC, acc);
    cycle(1'b0, 1'b1, 16'h5678, acc);
    cycle(1'b0, 1'b0, 16'h0000, acc);

    // Randomized traffic with sporadic collisions, spanning a burst.
    for (int k = 0; k < 1200; k++) begin
      rd = ($urandom_range(0, 15) == 0) ? SYNC : 16'($urandom);
      cycle(1'b0, 1'($urandom_range(0, 9) != 0), rd, acc);
    end

    // Reach the second word of a periodic burst in u0, then retrain.
    n = 0;
    while (m_ins[0] != BURST - 1 && n < 1500) begin
      cycle(1'b0, 1'b1, 16'($urandom), acc);
      n++;
    end
    chk("burst_reached", 0, 32'(m_ins[0]), 32'(BURST - 1));
    cycle(1'b1, 1'b1, 16'($urandom), acc);
    chk("retrain_accept", 0, 32'(acc), 32'd0);

    // Retraining, then 1030 transfers so the next burst lands at 1024.
    w = 0; n = 0;
    while (w < 1030 && n < 1200) begin
      cycle(1'b0, 1'b1, 16'($urandom), acc);
      if (acc) w++;
      n++;
    end
    chk("post_retrain_words", 0, 32'(w), 32'd1030);

    // Retrain held for several cycles in DATA, then released.
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1, 16'($urandom), acc);
    for (int k = 0; k < TL + 20; k++)
      cycle(1'b0, 1'($urandom_range(0, 3) != 0), 16'($urandom), acc);

    // Asynchronous reset between edges while streaming.
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk_reset_outputs();
    @(posedge clk); #1;
    chk_reset_outputs();
    rst = 1'b0;
    for (int k = 0; k < TL + 10; k++)
      cycle(1'b0, 1'($urandom_range(0, 3) != 0), 16'($urandom), acc);

    // Long stream: u1 must never insert sync words or drop ready.
    for (int k = 0; k < 5000; k++) cycle(1'b0, 1'b1, 16'($urandom), acc);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sync_framer.md
SYNC_FRAMER -- requirements
Module: sync_framer

Interface
REQ-001 Parameter TRAIN_LEN, default 8'd32: number of sync words sent per training burst; legal range 1..255.
REQ-002 Parameter SYNC_PERIOD, default 16'd1024: number of accepted data words between periodic sync bursts; 0 disables periodic insertion.
REQ-003 Parameter SYNC_BURST, default 8'd4: number of sync words per periodic burst; legal range 1..255.
REQ-004 Port clk  input  1: single clock, all logic on its rising edge.
REQ-005 Port rst  input  1: reset, asynchronous, active-high.
REQ-006 Port retrain  input  1: synchronous request to restart training.
REQ-007 Port valid_in  input  1: upstream data word valid.
REQ-008 Port datain  input  16: upstream data word.
REQ-009 Port ready  output  1: block accepts datain this cycle.
REQ-010 Port valid  output  1: dataout carries a word, either data or sync.
REQ-011 Port dataout  output  16: serial-side word towards the lane serializer.
REQ-012 Port training  output  1: high while in state TRAIN.
REQ-013 Port sync_collide  output  1: one-cycle pulse when an emitted data word equals the sync pattern.

Function
REQ-014 The sync pattern SHALL be the constant 16'h817E (16'b1000_0001_0111_1110).
REQ-015 The FSM SHALL have three states: TRAIN, DATA and INSERT.
REQ-016 ready SHALL equal (state==DATA) && !retrain.
REQ-016a ready is decoded from the state register plus retrain only, with no path from valid_in.
REQ-017 A transfer SHALL occur only on a cycle where valid_in && ready.
REQ-018 valid, dataout and sync_collide SHALL be registered; a transfer at edge N appears on dataout after edge N+1 (latency 1).
REQ-019 In TRAIN, every cycle SHALL load dataout=16'h817E and valid=1.
REQ-019a In TRAIN, train_cnt SHALL increment each cycle.
REQ-019b After the TRAIN_LEN-th sync word is loaded, the FSM SHALL move to DATA with train_cnt cleared.
REQ-020 In DATA, a transfer SHALL load dataout=datain and valid=1.
REQ-020a In DATA, a cycle with no transfer SHALL load valid=0 and dataout=16'h0000.
REQ-021 In DATA with SYNC_PERIOD!=0, period_cnt SHALL increment on each transfer.
REQ-021a The transfer that makes period_cnt reach SYNC_PERIOD SHALL clear period_cnt and move the FSM to INSERT on the same edge.
REQ-022 In INSERT, every cycle SHALL load dataout=16'h817E and valid=1.
REQ-022a After SYNC_BURST sync words, the FSM SHALL return to DATA.
REQ-023 In INSERT the FSM SHALL keep ready=0, and period_cnt SHALL NOT count.
REQ-024 sync_collide SHALL pulse for one cycle, aligned with the dataout word, when a transferred datain equals 16'h817E.
REQ-024a The colliding word SHALL still be emitted unchanged.
REQ-025 A retrain high in any state SHALL force TRAIN on the next edge and clear train_cnt, period_cnt and burst_cnt.
REQ-025a The cycle in which retrain is high accepts no word (ready=0).
REQ-025b On that edge, valid and dataout SHALL load 1 and 16'h817E, so training begins on that edge.
REQ-026 retrain held high SHALL keep the FSM in TRAIN with train_cnt held at 0, so the sync pattern is emitted continuously.
REQ-027 If retrain and the final-count condition of TRAIN or INSERT occur in the same cycle, retrain SHALL take priority.
REQ-028 training SHALL be a registered output equal to (state==TRAIN).

Reset
REQ-029 On rst high, the block SHALL immediately force state=TRAIN, valid=0, dataout=16'h0000, sync_collide=0 and training=1, independent of clk.
REQ-029a On rst high, all counters SHALL clear to 0, and ready SHALL be 0 (no combinational path from rst needed beyond this).
REQ-030 The first rising edge after rst deasserts SHALL load the first training sync word.
REQ-030a A reset asserted mid-burst or mid-data SHALL abandon the burst, with no partial-burst resumption.

Verification
REQ-031 Release rst, hold valid_in=0 -> exactly 32 consecutive cycles of valid=1 and dataout=16'h817E with training=1, then training=0, ready=1, and valid=0 while idle.
REQ-032 After training, drive 1024 back-to-back words 0x0000..0x03FF -> the words appear in order with 1-cycle latency; after word 0x03FF, 4 sync words follow with ready=0 for those 4 cycles; then ready=1 and data resumes with 0x0400.
REQ-033 After training, send 0x1234, 0x817E, 0x5678 -> all three appear on dataout unchanged, and sync_collide is high only in the 0x817E output cycle.
REQ-034 Assert retrain for 1 cycle during the 2nd word of a periodic burst -> ready=0 that cycle, then 32 sync words with training=1, then DATA with period_cnt=0, so the next periodic burst occurs after 1024 more transfers.
REQ-035 Assert rst asynchronously between edges while streaming -> valid, dataout and ready go to 0 at once, training goes to 1, and after release a full 32-word training burst is observed.
REQ-036 Build with SYNC_PERIOD=0 and stream 5000 words -> no sync words are inserted after training, and ready stays 1 throughout.
